// File: rtl/router_pkg.sv
// Shared definitions for the router read-side scheduler.
// Contents: read FSM state enum, port count, header length-field LSB,
// default watchdog timeout, and a one-hot to index helper.
package router_pkg;

  localparam int unsigned NUM_PORTS   = 3;
  localparam int unsigned LEN_LSB     = 2;
  localparam int unsigned DEF_TIMEOUT = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } rd_state_e;

  // Index of the set bit in a one-hot port vector (0 when vector is zero).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational rotate-priority picker.
// Ports:
//   req        in  3  per-port request (FIFO non-empty)
//   last_grant in  2  index of the port served last; search starts after it
//   pick       out 3  one-hot winner, zero when no request
//   found      out 1  a winner exists
module router_rr_pick
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last_grant,
  output logic [NUM_PORTS-1:0] pick,
  output logic                 found
);

  logic [1:0] idx;

  // Visit last+1, last+2, last+3 (mod 3); first requester wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = 2'((32'(last_grant) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_rd_arb.sv
// Read-side scheduler for the 1x3 router: shares one downstream read channel
// among three output FIFOs with a packet-granular round-robin grant and a
// per-packet stall watchdog.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   fifo_empty[2:0]       per-port FIFO empty flags
//   fifo_data_0/1/2       FIFO head bytes
//   rd_ready              downstream can take a byte this cycle
//   read_enb[2:0]         per-port FIFO pop (combinational)
//   grant[2:0]            registered one-hot grant
//   data_out, valid_out   granted head byte / granted FIFO non-empty
//   sop, eop              header / parity byte on the channel
//   soft_reset[2:0]       one-cycle pulse to a port whose packet timed out
//   busy                  a packet is in progress
// Optional build macro ROUTER_RD_ARB_STATS_EN adds pkt_cnt_0/1/2 (16-bit,
// wrapping) and abort_cnt (8-bit, saturating).
module router_rd_arb
  import router_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CW      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data_0,
  input  logic [WIDTH-1:0]     fifo_data_1,
  input  logic [WIDTH-1:0]     fifo_data_2,
  input  logic                 rd_ready,
  output logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] grant,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic                 sop,
  output logic                 eop,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 busy
`ifdef ROUTER_RD_ARB_STATS_EN
  ,
  output logic [15:0]          pkt_cnt_0,
  output logic [15:0]          pkt_cnt_1,
  output logic [15:0]          pkt_cnt_2,
  output logic [7:0]           abort_cnt
`endif
);

  localparam int unsigned LW = WIDTH - LEN_LSB;

  rd_state_e            state, state_nxt;
  logic [NUM_PORTS-1:0] grant_nxt, soft_nxt, pick;
  logic [1:0]           last_grant, last_nxt, gidx;
  logic [LW-1:0]        len_cnt, len_nxt, hdr_len;
  logic [CW-1:0]        to_cnt, to_nxt;
  logic                 fire, to_hit, pick_found;
  logic [WIDTH-1:0]     head [NUM_PORTS];

  assign head[0] = fifo_data_0;
  assign head[1] = fifo_data_1;
  assign head[2] = fifo_data_2;

  router_rr_pick u_pick (
    .req        (~fifo_empty),
    .last_grant (last_grant),
    .pick       (pick),
    .found      (pick_found)
  );

  // Channel mux: grant is one-hot or zero, so at most one term selects.
  always_comb begin
    data_out  = '0;
    valid_out = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        data_out  = head[i];
        valid_out = ~fifo_empty[i];
      end
    end
  end

  assign fire     = valid_out & rd_ready;
  assign read_enb = grant & ~fifo_empty & {NUM_PORTS{rd_ready}};
  assign sop      = valid_out & (state == HDR);
  assign eop      = valid_out & (state == PARITY);
  assign busy     = (state != IDLE);
  assign hdr_len  = data_out[WIDTH-1:LEN_LSB];
  assign gidx     = onehot_to_idx(grant);
  assign to_hit   = (to_cnt == CW'(TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'd2;
      len_cnt    <= '0;
      to_cnt     <= '0;
      soft_reset <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      len_cnt    <= len_nxt;
      to_cnt     <= to_nxt;
      soft_reset <= soft_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, walk the packet on fires, abort on stall.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    len_nxt   = len_cnt;
    to_nxt    = to_cnt;
    soft_nxt  = '0;
    if (state == IDLE) begin
      to_nxt = '0;
      if (pick_found) begin
        grant_nxt = pick;
        state_nxt = HDR;
      end
    end else if (fire) begin
      // A fire on the terminal count still wins over the watchdog.
      to_nxt = '0;
      case (state)
        HDR: begin
          if (hdr_len == '0) begin
            state_nxt = PARITY;
          end else begin
            len_nxt   = hdr_len;
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          len_nxt = len_cnt - LW'(1);
          if (len_cnt == LW'(1)) state_nxt = PARITY;
        end
        PARITY: begin
          last_nxt  = gidx;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end else if (to_hit) begin
      soft_nxt  = grant;
      last_nxt  = gidx;
      grant_nxt = '0;
      to_nxt    = '0;
      state_nxt = IDLE;
    end else begin
      to_nxt = to_cnt + CW'(1);
    end
  end

`ifdef ROUTER_RD_ARB_STATS_EN
  logic pkt_done_c, abort_c;

  assign pkt_done_c = fire & (state == PARITY);
  assign abort_c    = (state != IDLE) & ~fire & to_hit;

  // Completed-packet counters wrap; abort counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
      pkt_cnt_2 <= '0;
      abort_cnt <= '0;
    end else begin
      if (pkt_done_c) begin
        case (gidx)
          2'd0:    pkt_cnt_0 <= pkt_cnt_0 + 16'd1;
          2'd1:    pkt_cnt_1 <= pkt_cnt_1 + 16'd1;
          2'd2:    pkt_cnt_2 <= pkt_cnt_2 + 16'd1;
          default: ;
        endcase
      end
      if (abort_c && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_rd_arb.sv
// Self-checking bench for router_rd_arb. FIFOs are byte queues; a
// packet-level model (granted port, bytes consumed, packet length, stall
// count) predicts every output each cycle.
module tb_router_rd_arb;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fifo_empty;
  logic [7:0] fifo_data_0, fifo_data_1, fifo_data_2;
  logic       rd_ready;
  logic [2:0] read_enb, grant, soft_reset;
  logic [7:0] data_out;
  logic       valid_out, sop, eop, busy;

  router_rd_arb dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data_0 (fifo_data_0),
    .fifo_data_1 (fifo_data_1),
    .fifo_data_2 (fifo_data_2),
    .rd_ready    (rd_ready),
    .read_enb    (read_enb),
    .grant       (grant),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .sop         (sop),
    .eop         (eop),
    .soft_reset  (soft_reset),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] drv [3];
  int total = 0, bad = 0;
  int mp, mlast, mpos, mtotal, mstall;
  logic [2:0] msoft;
  int re_cnt [3];
  int sr_cnt [3];

  function automatic int qsize(input int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qhead(input int p);
    case (p)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int p);
    case (p)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int p, input logic [7:0] b);
    case (p)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  function automatic void qclear(input int p);
    case (p)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic push_pkt(input int p, input int len);
    logic [7:0] h;
    h = {6'(len), 2'($urandom)};
    qpush(p, h);
    for (int i = 0; i < len; i++) qpush(p, 8'($urandom));
    qpush(p, 8'($urandom));
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mp = -1; mlast = 2; mpos = 0; mtotal = 0; mstall = 0; msoft = 3'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      fifo_empty[i] = (qsize(i) == 0);
      drv[i] = (qsize(i) > 0) ? qhead(i) : 8'($urandom);
    end
    fifo_data_0 = drv[0];
    fifo_data_1 = drv[1];
    fifo_data_2 = drv[2];
  endtask

  // One cycle: drive FIFOs, check outputs against the model, advance model.
  task automatic step();
    logic [2:0] eg, ere;
    logic       av;
    logic [7:0] ed, b;
    bit         got;
    int         c;
    drive();
    #1;
    eg  = (mp >= 0) ? 3'(1 << mp) : 3'b0;
    av  = (mp >= 0) && (qsize(mp) > 0);
    ed  = (mp >= 0) ? drv[mp] : 8'h00;
    ere = (av && rd_ready) ? eg : 3'b0;
    chk("grant",      32'(grant),      32'(eg));
    chk("read_enb",   32'(read_enb),   32'(ere));
    chk("valid_out",  32'(valid_out),  32'(av));
    chk("data_out",   32'(data_out),   32'(ed));
    chk("sop",        32'(sop),        32'(av && mpos == 0));
    chk("eop",        32'(eop),        32'(av && mpos > 0 && mpos == mtotal - 1));
    chk("busy",       32'(busy),       32'(mp >= 0));
    chk("soft_reset", 32'(soft_reset), 32'(msoft));
    for (int i = 0; i < 3; i++) begin
      if (read_enb[i] === 1'b1) re_cnt[i]++;
      if (soft_reset[i] === 1'b1) sr_cnt[i]++;
    end
    msoft = 3'b0;
    if (mp < 0) begin
      got = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        c = (mlast + k) % 3;
        if (!got && qsize(c) > 0) begin
          got = 1'b1; mp = c; mpos = 0; mstall = 0;
        end
      end
    end else if (av && rd_ready) begin
      b = qpop(mp);
      if (mpos == 0) mtotal = int'(b >> 2) + 2;
      mpos++;
      mstall = 0;
      if (mpos == mtotal) begin
        mlast = mp; mp = -1;
      end
    end else if (mstall == TO - 1) begin
      msoft = 3'(1 << mp);
      qclear(mp);
      mlast = mp; mp = -1; mstall = 0;
    end else begin
      mstall++;
    end
    @(negedge clk);
  endtask

  task automatic run_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (mp < 0 && qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0) begin
        step();
        return;
      end
      step();
    end
    total++;
    bad++;
    $error("FAIL idle_wait got=busy exp=idle within %0d cycles", budget);
  endtask

  task automatic run_to_pos(input int pos, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (mp >= 0 && mpos == pos) return;
      step();
    end
    total++;
    bad++;
    $error("FAIL pos_wait got=%0d exp=%0d", mpos, pos);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin re_cnt[i] = 0; sr_cnt[i] = 0; end
    model_reset();
    reset = 1'b1;
    rd_ready = 1'b0;
    drive();
    @(negedge clk);
    #1;
    chk("rst_grant",    32'(grant),      32'h0);
    chk("rst_read_enb", 32'(read_enb),   32'h0);
    chk("rst_soft",     32'(soft_reset), 32'h0);
    chk("rst_busy",     32'(busy),       32'h0);
    chk("rst_valid",    32'(valid_out),  32'h0);
    chk("rst_data",     32'(data_out),   32'h0);
    @(negedge clk);

    // Single packet on port 1, length 3.
    qpush(1, 8'h0C);
    for (int i = 0; i < 4; i++) qpush(1, 8'($urandom));
    rd_ready = 1'b1;
    reset = 1'b0;
    run_idle(40);
    chk("single_fires", 32'(re_cnt[1]), 32'd5);

    // Round robin with length-1 packets on every port.
    for (int p = 0; p < 3; p++) push_pkt(p, 1);
    push_pkt(0, 1);
    run_idle(60);

    // Backpressure mid-payload.
    push_pkt(0, 4);
    run_to_pos(2, 20);
    rd_ready = 1'b0;
    repeat (10) step();
    rd_ready = 1'b1;
    run_idle(40);
    chk("bp_no_soft", 32'(sr_cnt[0]), 32'd0);

    // Watchdog abort on port 2.
    push_pkt(2, 2);
    rd_ready = 1'b0;
    repeat (34) step();
    chk("to_soft_pulses", 32'(sr_cnt[2]), 32'd1);
    rd_ready = 1'b1;
    for (int p = 0; p < 3; p++) push_pkt(p, 1);
    run_idle(60);

    // Zero-length packet on port 0.
    qpush(0, 8'h00);
    qpush(0, 8'($urandom));
    run_idle(20);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        int p;
        p = int'($urandom_range(0, 2));
        if (qsize(p) < 12) push_pkt(p, int'($urandom_range(0, 5)));
      end
      step();
    end
    rd_ready = 1'b1;
    run_idle(300);

    // Asynchronous reset in the middle of a payload.
    push_pkt(1, 5);
    run_to_pos(2, 20);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_grant",    32'(grant),    32'h0);
    chk("arst_read_enb", 32'(read_enb), 32'h0);
    chk("arst_busy",     32'(busy),     32'h0);
    @(negedge clk);
    for (int p = 0; p < 3; p++) qclear(p);
    model_reset();
    reset = 1'b0;
    for (int p = 0; p < 3; p++) push_pkt(p, 2);
    run_idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
